// File: rtl/round_controller.sv
// Pong match sequencer: serve/play/point/game-over FSM, scores, ball gating and paddle move arbitration.
// Outputs are registered one frame after the sample; there is no backpressure, and every input is sampled each frame.
module round_controller #(
   parameter int SERVE_FRAMES  = 60,
   parameter int SCORED_FRAMES = 90,
   parameter int WIN_SCORE     = 7,
   parameter int CPU_DEADBAND  = 2,
   parameter int CPU_REACT_X   = 80
) (
   input  logic       sixtyhz_clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       cpu_mode,
   input  logic       p1_up,
   input  logic       p1_down,
   input  logic       p2_up,
   input  logic       p2_down,
   input  logic [7:0] b_x,
   input  logic [6:0] b_y,
   input  logic [6:0] paddle2_y,
   input  logic       goal_left,
   input  logic       goal_right,
   output logic       inc_p1_y,
   output logic       dec_p1_y,
   output logic       inc_p2_y,
   output logic       dec_p2_y,
   output logic       cpu,
   output logic       ball_reset,
   output logic       ball_enable,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic [1:0] winner,
   output logic [2:0] phase
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SERVE  = 3'd1;
   localparam logic [2:0] S_PLAY   = 3'd2;
   localparam logic [2:0] S_SCORED = 3'd3;
   localparam logic [2:0] S_OVER   = 3'd4;

   // Timer only ever holds a load value minus one, so clog2 of the larger period suffices.
   localparam int TMAX = (SERVE_FRAMES > SCORED_FRAMES) ? SERVE_FRAMES : SCORED_FRAMES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] SERVE_LD  = TW'(SERVE_FRAMES - 1);
   localparam logic [TW-1:0] SCORED_LD = TW'(SCORED_FRAMES - 1);
   localparam logic [3:0]    WIN_S     = 4'(WIN_SCORE);
   localparam logic [8:0]    DEADBAND  = 9'(CPU_DEADBAND);
   localparam logic [7:0]    REACT_X   = 8'(CPU_REACT_X);

   logic [2:0]    r_state;
   logic [TW-1:0] r_timer;
   logic          r_start_q;
   logic [3:0]    r_score1;
   logic [3:0]    r_score2;
   logic [1:0]    r_winner;
   logic          r_cpu;
   logic          r_inc_p1;
   logic          r_dec_p1;
   logic          r_inc_p2;
   logic          r_dec_p2;
   logic          r_ball_reset;
   logic          r_ball_enable;

   logic [2:0]    w_state_nxt;
   logic [TW-1:0] w_timer_nxt;
   logic [3:0]    w_score1_nxt;
   logic [3:0]    w_score2_nxt;
   logic [1:0]    w_winner_nxt;
   logic          w_cpu_nxt;
   logic          w_inc_p1_nxt;
   logic          w_dec_p1_nxt;
   logic          w_inc_p2_nxt;
   logic          w_dec_p2_nxt;
   logic          w_ball_reset_nxt;
   logic          w_ball_enable_nxt;

   logic          w_start_ev;
   logic [3:0]    w_score1_inc;
   logic [3:0]    w_score2_inc;
   logic          w_goal_p1;
   logic          w_goal_p2;
   logic [7:0]    w_centre;
   logic [8:0]    w_by_ext;
   logic          w_track;
   logic          w_cpu_dec;
   logic          w_cpu_inc;
   logic          w_moving;

   assign w_start_ev   = start & ~r_start_q;
   assign w_score1_inc = r_score1 + 4'd1;
   assign w_score2_inc = r_score2 + 4'd1;
   assign w_goal_p1    = goal_right & ~goal_left;
   assign w_goal_p2    = goal_left & ~goal_right;

   // CPU opponent aims the paddle centre (top + 10) at the ball, with a deadband.
   assign w_centre  = {1'b0, paddle2_y} + 8'd10;
   assign w_by_ext  = {2'b00, b_y};
   assign w_track   = (b_x >= REACT_X);
   assign w_cpu_dec = w_track && ((w_by_ext + DEADBAND) < {1'b0, w_centre});
   assign w_cpu_inc = w_track && !w_cpu_dec && (w_by_ext > ({1'b0, w_centre} + DEADBAND));

   always_ff @(posedge sixtyhz_clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_timer_nxt  = r_timer;
      w_score1_nxt = r_score1;
      w_score2_nxt = r_score2;
      w_winner_nxt = r_winner;
      w_cpu_nxt    = r_cpu;
      case (r_state)
         S_IDLE, S_OVER: begin
            if (w_start_ev) begin
               w_score1_nxt = 4'd0;
               w_score2_nxt = 4'd0;
               w_winner_nxt = 2'd0;
               w_cpu_nxt    = cpu_mode;
               w_timer_nxt  = SERVE_LD;
               w_state_nxt  = S_SERVE;
            end
         end
         S_SERVE: begin
            if (r_timer == '0) begin
               w_state_nxt = S_PLAY;
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         S_PLAY: begin
            if (goal_left || goal_right) begin
               w_timer_nxt = SCORED_LD;
               w_state_nxt = S_SCORED;
               if (w_goal_p1) begin
                  w_score1_nxt = w_score1_inc;
                  if (w_score1_inc == WIN_S) begin
                     w_winner_nxt = 2'd1;
                     w_state_nxt  = S_OVER;
                  end
               end else if (w_goal_p2) begin
                  w_score2_nxt = w_score2_inc;
                  if (w_score2_inc == WIN_S) begin
                     w_winner_nxt = 2'd2;
                     w_state_nxt  = S_OVER;
                  end
               end
            end
         end
         S_SCORED: begin
            if (r_timer == '0) begin
               w_timer_nxt = SERVE_LD;
               w_state_nxt = S_SERVE;
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Decoded from the next state so move/ball outputs flip on the same edge as phase.
   always_comb begin
      w_moving          = (w_state_nxt == S_SERVE) || (w_state_nxt == S_PLAY);
      w_ball_reset_nxt  = (w_state_nxt != S_PLAY);
      w_ball_enable_nxt = (w_state_nxt == S_PLAY);
      w_inc_p1_nxt      = w_moving && p1_down && !p1_up;
      w_dec_p1_nxt      = w_moving && p1_up && !p1_down;
      w_inc_p2_nxt      = 1'b0;
      w_dec_p2_nxt      = 1'b0;
      if (w_moving) begin
         if (w_cpu_nxt) begin
            w_inc_p2_nxt = w_cpu_inc;
            w_dec_p2_nxt = w_cpu_dec;
         end else begin
            w_inc_p2_nxt = p2_down && !p2_up;
            w_dec_p2_nxt = p2_up && !p2_down;
         end
      end
   end

   always_ff @(posedge sixtyhz_clk) begin
      if (!resetn) begin
         r_timer       <= '0;
         r_start_q     <= 1'b0;
         r_score1      <= 4'd0;
         r_score2      <= 4'd0;
         r_winner      <= 2'd0;
         r_cpu         <= 1'b0;
         r_inc_p1      <= 1'b0;
         r_dec_p1      <= 1'b0;
         r_inc_p2      <= 1'b0;
         r_dec_p2      <= 1'b0;
         r_ball_reset  <= 1'b1;
         r_ball_enable <= 1'b0;
      end else begin
         r_timer       <= w_timer_nxt;
         r_start_q     <= start;
         r_score1      <= w_score1_nxt;
         r_score2      <= w_score2_nxt;
         r_winner      <= w_winner_nxt;
         r_cpu         <= w_cpu_nxt;
         r_inc_p1      <= w_inc_p1_nxt;
         r_dec_p1      <= w_dec_p1_nxt;
         r_inc_p2      <= w_inc_p2_nxt;
         r_dec_p2      <= w_dec_p2_nxt;
         r_ball_reset  <= w_ball_reset_nxt;
         r_ball_enable <= w_ball_enable_nxt;
      end
   end

   assign phase       = r_state;
   assign score1      = r_score1;
   assign score2      = r_score2;
   assign winner      = r_winner;
   assign cpu         = r_cpu;
   assign inc_p1_y    = r_inc_p1;
   assign dec_p1_y    = r_dec_p1;
   assign inc_p2_y    = r_inc_p2;
   assign dec_p2_y    = r_dec_p2;
   assign ball_reset  = r_ball_reset;
   assign ball_enable = r_ball_enable;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: match flow, move arbitration, CPU tracking, win and reset.
module tb_round_controller;

   logic       sixtyhz_clk = 1'b0;
   logic       resetn      = 1'b0;
   logic       start       = 1'b0;
   logic       cpu_mode    = 1'b0;
   logic       p1_up       = 1'b0;
   logic       p1_down     = 1'b0;
   logic       p2_up       = 1'b0;
   logic       p2_down     = 1'b0;
   logic [7:0] b_x         = 8'd0;
   logic [6:0] b_y         = 7'd0;
   logic [6:0] paddle2_y   = 7'd0;
   logic       goal_left   = 1'b0;
   logic       goal_right  = 1'b0;
   logic       inc_p1_y, dec_p1_y, inc_p2_y, dec_p2_y;
   logic       cpu, ball_reset, ball_enable;
   logic [3:0] score1, score2;
   logic [1:0] winner;
   logic [2:0] phase;

   int n_checks = 0;
   int n_fail   = 0;

   round_controller dut (
      .sixtyhz_clk (sixtyhz_clk),
      .resetn      (resetn),
      .start       (start),
      .cpu_mode    (cpu_mode),
      .p1_up       (p1_up),
      .p1_down     (p1_down),
      .p2_up       (p2_up),
      .p2_down     (p2_down),
      .b_x         (b_x),
      .b_y         (b_y),
      .paddle2_y   (paddle2_y),
      .goal_left   (goal_left),
      .goal_right  (goal_right),
      .inc_p1_y    (inc_p1_y),
      .dec_p1_y    (dec_p1_y),
      .inc_p2_y    (inc_p2_y),
      .dec_p2_y    (dec_p2_y),
      .cpu         (cpu),
      .ball_reset  (ball_reset),
      .ball_enable (ball_enable),
      .score1      (score1),
      .score2      (score2),
      .winner      (winner),
      .phase       (phase)
   );

   always #5 sixtyhz_clk = ~sixtyhz_clk;

   task automatic step(input int n);
      repeat (n) @(posedge sixtyhz_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_p2(input string tag, input logic exp_inc, input logic exp_dec);
      chk({tag, "_inc"}, {7'd0, inc_p2_y}, {7'd0, exp_inc});
      chk({tag, "_dec"}, {7'd0, dec_p2_y}, {7'd0, exp_dec});
   endtask

   initial begin
      // reset state
      step(2);
      chk("rst_phase", {5'd0, phase}, 8'd0);
      chk("rst_ball_reset", {7'd0, ball_reset}, 8'd1);
      chk("rst_ball_enable", {7'd0, ball_enable}, 8'd0);
      chk("rst_score1", {4'd0, score1}, 8'd0);
      chk("rst_winner", {6'd0, winner}, 8'd0);
      chk("rst_cpu", {7'd0, cpu}, 8'd0);
      resetn = 1'b1;
      step(1);
      chk("idle_phase", {5'd0, phase}, 8'd0);

      // start rises; held high for the rest of the match
      start = 1'b1;
      step(1);
      chk("serve_phase", {5'd0, phase}, 8'd1);
      chk("serve_cpu", {7'd0, cpu}, 8'd0);
      step(59);
      chk("serve_last_frame", {5'd0, phase}, 8'd1);
      step(1);
      chk("play_phase", {5'd0, phase}, 8'd2);
      chk("play_ball_enable", {7'd0, ball_enable}, 8'd1);
      chk("play_ball_reset", {7'd0, ball_reset}, 8'd0);

      // human paddles
      p1_up = 1'b1;
      step(1);
      chk("p1_up_dec", {7'd0, dec_p1_y}, 8'd1);
      chk("p1_up_inc", {7'd0, inc_p1_y}, 8'd0);
      p1_down = 1'b1;
      step(1);
      chk("p1_both_dec", {7'd0, dec_p1_y}, 8'd0);
      chk("p1_both_inc", {7'd0, inc_p1_y}, 8'd0);
      p1_up = 1'b0;
      p2_up = 1'b1;
      step(1);
      chk("p1_down_inc", {7'd0, inc_p1_y}, 8'd1);
      chk_p2("p2_human_up", 1'b0, 1'b1);

      // goal_right with p1_down still held: score, SCORED, commands off
      goal_right = 1'b1;
      step(1);
      goal_right = 1'b0;
      chk("goal_r_score1", {4'd0, score1}, 8'd1);
      chk("goal_r_phase", {5'd0, phase}, 8'd3);
      chk("scored_inc_p1", {7'd0, inc_p1_y}, 8'd0);
      chk("scored_ball_reset", {7'd0, ball_reset}, 8'd1);
      chk("scored_ball_enable", {7'd0, ball_enable}, 8'd0);
      goal_left = 1'b1;
      step(1);
      goal_left = 1'b0;
      chk("scored_goal_ignored", {4'd0, score2}, 8'd0);
      step(88);
      chk("scored_last_frame", {5'd0, phase}, 8'd3);
      step(1);
      chk("scored_to_serve", {5'd0, phase}, 8'd1);
      chk("serve_inc_p1", {7'd0, inc_p1_y}, 8'd1);
      p1_down = 1'b0;
      p2_up   = 1'b0;
      step(60);
      chk("play2_phase", {5'd0, phase}, 8'd2);

      // simultaneous goals: no score, still a point pause
      goal_left  = 1'b1;
      goal_right = 1'b1;
      step(1);
      goal_left  = 1'b0;
      goal_right = 1'b0;
      chk("both_score1", {4'd0, score1}, 8'd1);
      chk("both_score2", {4'd0, score2}, 8'd0);
      chk("both_phase", {5'd0, phase}, 8'd3);
      step(150);
      chk("play3_phase", {5'd0, phase}, 8'd2);

      // run player 1 up to 6
      for (int i = 0; i < 5; i++) begin
         goal_right = 1'b1;
         step(1);
         goal_right = 1'b0;
         chk("loop_score1", {4'd0, score1}, 8'(i + 2));
         step(150);
      end
      chk("pre_win_phase", {5'd0, phase}, 8'd2);

      // winning goal
      goal_right = 1'b1;
      step(1);
      goal_right = 1'b0;
      chk("win_score1", {4'd0, score1}, 8'd7);
      chk("win_winner", {6'd0, winner}, 8'd1);
      chk("win_phase", {5'd0, phase}, 8'd4);
      chk("over_ball_reset", {7'd0, ball_reset}, 8'd1);
      goal_left = 1'b1;
      step(1);
      goal_left = 1'b0;
      chk("over_goal_score2", {4'd0, score2}, 8'd0);
      chk("over_goal_score1", {4'd0, score1}, 8'd7);
      step(4);
      chk("over_held_start", {5'd0, phase}, 8'd4);

      // new start edge with CPU opponent
      start    = 1'b0;
      cpu_mode = 1'b1;
      step(1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("restart_phase", {5'd0, phase}, 8'd1);
      chk("restart_score1", {4'd0, score1}, 8'd0);
      chk("restart_winner", {6'd0, winner}, 8'd0);
      chk("restart_cpu", {7'd0, cpu}, 8'd1);
      step(60);
      chk("cpu_play_phase", {5'd0, phase}, 8'd2);

      // CPU tracking: paddle2_y 50 -> centre 60, deadband 2; p2_up always ignored
      paddle2_y = 7'd50;
      b_x       = 8'd100;
      p2_up     = 1'b1;
      b_y = 7'd40; step(1); chk_p2("cpu_y40", 1'b0, 1'b1);
      b_y = 7'd61; step(1); chk_p2("cpu_y61", 1'b0, 1'b0);
      b_y = 7'd70; step(1); chk_p2("cpu_y70", 1'b1, 1'b0);
      b_y = 7'd58; step(1); chk_p2("cpu_y58", 1'b0, 1'b0);
      b_y = 7'd57; step(1); chk_p2("cpu_y57", 1'b0, 1'b1);
      b_y = 7'd62; step(1); chk_p2("cpu_y62", 1'b0, 1'b0);
      b_y = 7'd63; step(1); chk_p2("cpu_y63", 1'b1, 1'b0);
      b_y = 7'd70; b_x = 8'd79; step(1); chk_p2("cpu_x79", 1'b0, 1'b0);
      b_x = 8'd80; step(1); chk_p2("cpu_x80", 1'b1, 1'b0);
      b_x = 8'd20; p2_down = 1'b1; p2_up = 1'b0;
      step(1); chk_p2("cpu_x20", 1'b0, 1'b0);
      b_x = 8'd100;

      // player 2 scores three; CPU commands stop in SCORED
      for (int i = 0; i < 3; i++) begin
         goal_left = 1'b1;
         step(1);
         goal_left = 1'b0;
         chk("loop_score2", {4'd0, score2}, 8'(i + 1));
         chk("scored_cpu_inc", {7'd0, inc_p2_y}, 8'd0);
         if (i < 2) step(150);
      end
      step(90);
      chk("pre_rst_phase", {5'd0, phase}, 8'd1);
      step(10);

      // reset mid-serve
      resetn = 1'b0;
      step(1);
      chk("midrst_phase", {5'd0, phase}, 8'd0);
      chk("midrst_score2", {4'd0, score2}, 8'd0);
      chk("midrst_ball_reset", {7'd0, ball_reset}, 8'd1);
      chk("midrst_cpu", {7'd0, cpu}, 8'd0);
      chk("midrst_inc_p2", {7'd0, inc_p2_y}, 8'd0);
      resetn = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/round_controller.md
# round_controller

Match-level sequencer for the pong datapath, clocked at the 60 Hz frame rate. It arbitrates player buttons and the built-in CPU opponent into the paddle-movement command strobes. It also runs the serve / play / point / game-over state machine, keeps both scores and gates the ball logic. It sits between the board inputs and the paddle and ball blocks, and replaces direct button wiring to the paddles.

## Interface
Parameters:
- SERVE_FRAMES, 60: frames spent in SERVE before play starts.
- SCORED_FRAMES, 90: frames of pause after a goal.
- WIN_SCORE, 7: score that ends the match (must be 1..15).
- CPU_DEADBAND, 2: CPU ignores ball/paddle-centre error of this many pixels or fewer.
- CPU_REACT_X, 80: CPU tracks only while b_x >= this value.

Ports:
- sixtyhz_clk  in  1  frame clock; all logic on its rising edge.
- resetn  in  1  reset; synchronous, active-low.
- start  in  1  level button; a rising edge is the start event.
- cpu_mode  in  1  1 = paddle 2 is CPU-driven; sampled only on a start event.
- p1_up, p1_down, p2_up, p2_down  in  1 each  raw button levels.
- b_x  in  8  ball x.
- b_y  in  7  ball y.
- paddle2_y  in  7  paddle 2 top y.
- goal_left  in  1  ball passed the left edge; point to player 2.
- goal_right  in  1  ball passed the right edge; point to player 1.
- inc_p1_y, dec_p1_y, inc_p2_y, dec_p2_y  out  1 each  registered paddle move commands.
- cpu  out  1  latched CPU mode.
- ball_reset  out  1  holds ball at centre.
- ball_enable  out  1  ball may move.
- score1, score2  out  4 each  scores.
- winner  out  2  0 = none, 1 = P1, 2 = P2.
- phase  out  3  current state code.

## Operation
- States and phase codes: IDLE = 0, SERVE = 1, PLAY = 2, SCORED = 3, OVER = 4. Codes 5-7 are unreachable; if entered, go to IDLE.
- Start event: start = 1 and start_q = 0, where start_q is start registered each frame.
- IDLE:
  - On a start event: clear scores, set winner = 0, latch cpu <= cpu_mode, load timer = SERVE_FRAMES - 1, go to SERVE.
- SERVE:
  - Decrement timer each frame.
  - When timer == 0, go to PLAY.
- PLAY:
  - goal_right only: score1 + 1.
  - goal_left only: score2 + 1.
  - Both asserted in the same frame: no score change.
  - Any goal: load timer = SCORED_FRAMES - 1, go to SCORED.
  - If the incremented score == WIN_SCORE: set winner, go to OVER instead of SCORED.
- SCORED:
  - When timer == 0: load timer = SERVE_FRAMES - 1, go to SERVE.
- OVER:
  - Hold scores and winner.
  - On a start event: behave exactly as the IDLE start event, including re-latching cpu.
- Goal inputs are ignored outside PLAY.
- Start events are ignored outside IDLE and OVER.
- Move commands are computed every frame and forced to 0 outside SERVE and PLAY.
  - Human paddle: up and down both pressed gives no command; up alone sets dec_*; down alone sets inc_*.
  - CPU paddle 2 (cpu = 1): ignore p2 buttons.
    - centre = {1'b0,paddle2_y} + 10, computed at 8 bits.
    - If b_x < CPU_REACT_X: no command.
    - Else if {1'b0,b_y} + CPU_DEADBAND < centre: dec_p2_y.
    - Else if {1'b0,b_y} > centre + CPU_DEADBAND: inc_p2_y.
    - Otherwise no command.
  - inc_* and dec_* for one paddle are never asserted together.
- ball_reset = 1 in every state except PLAY.
- ball_enable = 1 only in PLAY.
- Both are registered and decoded from the next state, so they change in the same edge as phase.

## Timing
- All outputs are registered.
- Reset values: phase = 0, all move commands = 0, cpu = 0, ball_reset = 1, ball_enable = 0, score1 = score2 = 0, winner = 0, start_q = 0, timer = 0.
- Reset wins over every other event, including a reset asserted mid-serve or mid-match.
- Move command latency: one frame from button or ball sample to output.
- Start event to phase = 1: one edge after the frame in which start rises.
- SERVE lasts exactly SERVE_FRAMES edges. SCORED lasts exactly SCORED_FRAMES edges.
- Goal sampled in PLAY: score and phase update on the same edge.
- Scores never exceed WIN_SCORE, and no further increments occur in OVER.
- A start held high across a state change does not retrigger; a new rising edge is required.

## Test plan
- Reset, then start rises with cpu_mode = 0 → phase 1 on the next edge, phase 2 after 60 more edges, ball_enable = 1, ball_reset = 0.
- PLAY, p1_up = 1 → dec_p1_y = 1 one frame later. p1_up = p1_down = 1 → both commands 0. Commands stay 0 in phase 3.
- cpu = 1, paddle2_y = 50 (centre 60), b_x = 100: b_y = 40 → dec_p2_y; b_y = 61 → none; b_y = 70 → inc_p2_y. With b_x = 20 → none. p2_up is ignored throughout.
- PLAY, goal_right pulse → score1 = 1, phase 3, back to phase 1 after 90 edges. goal_left and goal_right together → scores unchanged, phase 3.
- score1 = 6, goal_right → score1 = 7, winner = 1, phase 4. Further goals ignored. A new start edge → scores 0, winner 0, phase 1.
- resetn = 0 mid-SERVE with score2 = 3 → next edge phase 0, scores 0, ball_reset = 1.
